disp_page_ctrl: RTL and testbench
=================================

// Module: disp_page_ctrl
// PURPOSE
//  Parametrised display page selector and blink generator for the clock display path.
//  Sits between the time/date/alarm counters and the 7-seg driver; replaces the fixed time/date mux.
//  Adds: N pages, user page browsing, timed preview page, per-field blink with restart, auto-return timeout.
// PARAMETERS
//  NUM_PAGES       3           number of display pages (0=time, 1=date, 2=alarm, ...)
//  FIELDS          3           fields per page (e.g. hh/mm/ss)
//  FIELD_W         8           bits per field (packed BCD pair)
//  HOME_PAGE       0           page shown in NORMAL
//  PREVIEW_PAGE    1           page shown in PREVIEW
//  BLINK_HALF_CYC  25_000_000  clk cycles per blink half-period (>=2)
//  TIMEOUT_CYC     150_000_000 idle cycles before BROWSE/PREVIEW returns to NORMAL (>=2)
// PORTS
//  clk            in   1                        system clock
//  rst_n          in   1                        async reset, active low
//  page_data      in   NUM_PAGES*FIELDS*FIELD_W page p field f at [(p*FIELDS+f)*FIELD_W +: FIELD_W]
//  edit_en        in   1                        level: control FSM is in a set mode
//  edit_page      in   $clog2(NUM_PAGES)        page being edited (valid when edit_en)
//  edit_field     in   $clog2(FIELDS)           field being edited (blinks)
//  edit_adj       in   1                        level: adjust button held; forces edited field visible
//  preview_req    in   1                        level: preview button held (normal mode)
//  page_next      in   1                        1-cycle pulse: step to next page
//  disp_data      out  FIELDS*FIELD_W           registered data of cur_page
//  disp_blank     out  FIELDS                   1 = blank that field this cycle
//  cur_page       out  $clog2(NUM_PAGES)        page currently shown
//  preview_active out  1                        1 while in PREVIEW
// BEHAVIOUR
//  Reset: state=NORMAL, cur_page=HOME_PAGE, disp_data=0, disp_blank=0, preview_active=0, counters=0.
//  All outputs registered; disp_data = page_data[cur_page] sampled 1 cycle earlier (latency 1).
//  States: NORMAL, BROWSE, PREVIEW, EDIT. Per-cycle priority: edit_en > preview_req rise > page_next > timeout.
//  Any state, edit_en=1 -> EDIT; cur_page=edit_page (clamped to HOME_PAGE if >= NUM_PAGES).
//  EDIT, edit_en=0 -> NORMAL, cur_page=HOME_PAGE; blink off.
//  NORMAL, preview_req rising edge -> PREVIEW, cur_page=PREVIEW_PAGE, timer loaded TIMEOUT_CYC.
//  PREVIEW: timer reloads while preview_req=1; counts down when 0; reaches 0 -> NORMAL. page_next ignored.
//  NORMAL, page_next -> BROWSE, cur_page=(HOME_PAGE+1) mod NUM_PAGES, timer loaded.
//  BROWSE, page_next -> cur_page+1 mod NUM_PAGES, timer reloaded; if new page==HOME_PAGE -> NORMAL.
//  BROWSE, preview_req rise -> PREVIEW. BROWSE timer reaches 0 -> NORMAL.
//  Same cycle preview_req rise + page_next in NORMAL -> PREVIEW (page_next dropped).
//  preview_req rising edge detected with a 1-flop history register (reset 0).
//  Blink: phase counter 0..BLINK_HALF_CYC-1, phase bit toggles on wrap. Counter and phase cleared
//   (field visible) on EDIT entry and on any edit_field change, so a newly selected field shows first.
//  disp_blank[edit_field] = phase when state==EDIT && edit_adj==0 && edit_field<FIELDS; all other bits 0.
//  edit_adj=1 forces field visible and holds counter cleared; release restarts the visible half-period.
//  Outside EDIT, disp_blank=0 and blink counter idles at 0.
//  Timeout counter width $clog2(TIMEOUT_CYC+1); saturates at 0, never wraps.
// STRUCTURE
//  disp_pkg: typedef enum logic [1:0] {NORMAL, BROWSE, PREVIEW, EDIT} disp_state_e; page/field index
//   width localparam helpers; default timing constants.
//  Sub-module blink_gen (params HALF_CYC; ports clk, rst_n, en, restart, phase) instantiated once.
//  Top: state FSM, timeout counter, page mux + output registers.
// TESTING (NUM_PAGES=3, FIELDS=3, FIELD_W=8, BLINK_HALF_CYC=4, TIMEOUT_CYC=10)
//  Reset with page0=0x12_34_56: after release, 2nd clk -> disp_data=0x123456, cur_page=0, blank=000.
//  page_next x1 -> cur_page=1, state BROWSE; idle 10 cycles -> cur_page=0; page_next x3 -> NORMAL at page 0.
//  preview_req high 20 cycles then low -> cur_page=1 throughout, preview_active=1; returns to 0 exactly 10 cycles after release.
//  edit_en=1, edit_page=2, edit_field=1 -> cur_page=2; disp_blank = 000 x4, 010 x4, 000 x4 ...; edit_field->0 mid-blank -> 000 immediately, then 001 after 4.
//  edit_adj held during EDIT -> disp_blank=000 constant; edit_en and page_next same cycle -> EDIT wins.
//  Assert rst_n mid-PREVIEW and mid-blank -> all outputs 0/HOME next edge, async (no clk needed).

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types, index-width helpers and default timing constants for the
// display page controller.
package disp_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        BROWSE  = 2'd1,
        PREVIEW = 2'd2,
        EDIT    = 2'd3
    } disp_state_e;

    localparam int DEF_NUM_PAGES      = 3;
    localparam int DEF_FIELDS         = 3;
    localparam int DEF_FIELD_W        = 8;
    localparam int DEF_HOME_PAGE      = 0;
    localparam int DEF_PREVIEW_PAGE   = 1;
    localparam int DEF_BLINK_HALF_CYC = 25_000_000;
    localparam int DEF_TIMEOUT_CYC    = 150_000_000;

    // Width of an index selecting one of n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold every value 0..maxval.
    function automatic int cnt_w(input int maxval);
        return (maxval > 0) ? $clog2(maxval + 1) : 1;
    endfunction

endpackage

// File: rtl/disp_page_ctrl_blink_gen.sv
// Blink phase generator: phase toggles every HALF_CYC enabled cycles and
// restarts in the visible (phase=0) half whenever restart is raised.
module blink_gen
    import disp_pkg::*;
#(
    parameter int HALF_CYC = DEF_BLINK_HALF_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic phase
);

    localparam int CW = cnt_w(HALF_CYC - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!en || restart) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/disp_page_ctrl.sv
// Display page selector for the clock display path: page browsing, timed
// preview, edit-field blink and auto-return to the home page.
module disp_page_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_PAGES      = DEF_NUM_PAGES,
    parameter int FIELDS         = DEF_FIELDS,
    parameter int FIELD_W        = DEF_FIELD_W,
    parameter int HOME_PAGE      = DEF_HOME_PAGE,
    parameter int PREVIEW_PAGE   = DEF_PREVIEW_PAGE,
    parameter int BLINK_HALF_CYC = DEF_BLINK_HALF_CYC,
    parameter int TIMEOUT_CYC    = DEF_TIMEOUT_CYC
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_PAGES*FIELDS*FIELD_W-1:0] page_data,
    input  logic                                edit_en,
    input  logic [idx_w(NUM_PAGES)-1:0]         edit_page,
    input  logic [idx_w(FIELDS)-1:0]            edit_field,
    input  logic                                edit_adj,
    input  logic                                preview_req,
    input  logic                                page_next,
    output logic [FIELDS*FIELD_W-1:0]           disp_data,
    output logic [FIELDS-1:0]                   disp_blank,
    output logic [idx_w(NUM_PAGES)-1:0]         cur_page,
    output logic                                preview_active
);

    localparam int PW  = idx_w(NUM_PAGES);
    localparam int FW  = idx_w(FIELDS);
    localparam int PW1 = PW + 1;
    localparam int FW1 = FW + 1;
    localparam int TW  = cnt_w(TIMEOUT_CYC);
    localparam int DW  = FIELDS * FIELD_W;

    localparam logic [PW-1:0] HOME_IDX    = PW'(HOME_PAGE);
    localparam logic [PW-1:0] PREVIEW_IDX = PW'(PREVIEW_PAGE);
    localparam logic [PW-1:0] FIRST_IDX   = PW'((HOME_PAGE + 1) % NUM_PAGES);
    localparam logic [PW-1:0] LAST_IDX    = PW'(NUM_PAGES - 1);
    localparam logic [PW:0]   PAGE_LIMIT  = PW1'(NUM_PAGES);
    localparam logic [FW:0]   FIELD_LIMIT = FW1'(FIELDS);
    localparam logic [TW-1:0] TIMER_LOAD  = TW'(TIMEOUT_CYC);

    disp_state_e   state_q, state_d;
    logic [PW-1:0] page_q, page_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          req_hist_q;
    logic [FW-1:0] field_q;
    logic          adj_q;
    logic [DW-1:0] data_q, data_d;
    logic          active_q;

    logic          preview_rise;
    logic          timer_expired;
    logic [PW-1:0] step_page;
    logic [PW-1:0] edit_page_ok;
    logic          field_valid;
    logic          blink_en;
    logic          blink_restart;
    logic          blink_phase;

    assign preview_rise  = preview_req & ~req_hist_q;
    assign timer_expired = (timer_q <= TW'(1));
    assign step_page     = (page_q >= LAST_IDX) ? '0 : page_q + PW'(1);
    assign edit_page_ok  = ({1'b0, edit_page} < PAGE_LIMIT) ? edit_page : HOME_IDX;
    assign field_valid   = ({1'b0, field_q} < FIELD_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            page_q  <= HOME_IDX;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            timer_q <= timer_d;
        end
    end

    // The timer only counts in BROWSE/PREVIEW and is held at zero elsewhere;
    // it leaves for NORMAL on the cycle it would step from 1 to 0.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        timer_d = timer_q;
        if (edit_en) begin
            state_d = EDIT;
            page_d  = edit_page_ok;
            timer_d = '0;
        end else begin
            case (state_q)
                EDIT: begin
                    state_d = NORMAL;
                    page_d  = HOME_IDX;
                    timer_d = '0;
                end
                NORMAL: begin
                    if (preview_rise) begin
                        state_d = PREVIEW;
                        page_d  = PREVIEW_IDX;
                        timer_d = TIMER_LOAD;
                    end else if (page_next && (FIRST_IDX != HOME_IDX)) begin
                        state_d = BROWSE;
                        page_d  = FIRST_IDX;
                        timer_d = TIMER_LOAD;
                    end
                end
                BROWSE: begin
                    if (preview_rise) begin
                        state_d = PREVIEW;
                        page_d  = PREVIEW_IDX;
                        timer_d = TIMER_LOAD;
                    end else if (page_next) begin
                        page_d = step_page;
                        if (step_page == HOME_IDX) begin
                            state_d = NORMAL;
                            timer_d = '0;
                        end else begin
                            timer_d = TIMER_LOAD;
                        end
                    end else if (timer_expired) begin
                        state_d = NORMAL;
                        page_d  = HOME_IDX;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                PREVIEW: begin
                    if (preview_req) begin
                        timer_d = TIMER_LOAD;
                    end else if (timer_expired) begin
                        state_d = NORMAL;
                        page_d  = HOME_IDX;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                default: begin
                    state_d = NORMAL;
                    page_d  = HOME_IDX;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Holding adjust, and the cycle it is released, both restart the blink so
    // the field always begins a full visible half-period when it reappears.
    always_comb begin
        data_d        = page_data[int'(page_q) * DW +: DW];
        blink_en      = (state_d == EDIT);
        blink_restart = (state_q != EDIT) || (edit_field != field_q) || edit_adj || adj_q;
        disp_blank    = '0;
        if ((state_q == EDIT) && !adj_q && field_valid) begin
            for (int f = 0; f < FIELDS; f++) begin
                if (field_q == FW'(f)) begin
                    disp_blank[f] = blink_phase;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            active_q   <= 1'b0;
            req_hist_q <= 1'b0;
            field_q    <= '0;
            adj_q      <= 1'b0;
        end else begin
            data_q     <= data_d;
            active_q   <= (state_d == PREVIEW);
            req_hist_q <= preview_req;
            field_q    <= edit_field;
            adj_q      <= edit_adj;
        end
    end

    blink_gen #(
        .HALF_CYC (BLINK_HALF_CYC)
    ) u_blink (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (blink_en),
        .restart (blink_restart),
        .phase   (blink_phase)
    );

    assign disp_data      = data_q;
    assign cur_page       = page_q;
    assign preview_active = active_q;

endmodule

// File: tb/tb_disp_page_ctrl.sv
// Self-checking bench for disp_page_ctrl: directed vectors plus a cycle-level
// reference model compared on every falling clock edge.
`timescale 1ns/1ps
module tb_disp_page_ctrl;

    localparam int NP   = 3;
    localparam int NF   = 3;
    localparam int FWID = 8;
    localparam int HALF = 4;
    localparam int TOUT = 10;
    localparam int DW   = NF * FWID;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [NP*DW-1:0] page_data;
    logic            edit_en     = 1'b0;
    logic [1:0]      edit_page   = 2'd0;
    logic [1:0]      edit_field  = 2'd0;
    logic            edit_adj    = 1'b0;
    logic            preview_req = 1'b0;
    logic            page_next   = 1'b0;
    logic [DW-1:0]   disp_data;
    logic [NF-1:0]   disp_blank;
    logic [1:0]      cur_page;
    logic            preview_active;

    int testsRun    = 0;
    int testsFailed = 0;

    disp_page_ctrl #(
        .NUM_PAGES      (NP),
        .FIELDS         (NF),
        .FIELD_W        (FWID),
        .HOME_PAGE      (0),
        .PREVIEW_PAGE   (1),
        .BLINK_HALF_CYC (HALF),
        .TIMEOUT_CYC    (TOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .page_data      (page_data),
        .edit_en        (edit_en),
        .edit_page      (edit_page),
        .edit_field     (edit_field),
        .edit_adj       (edit_adj),
        .preview_req    (preview_req),
        .page_next      (page_next),
        .disp_data      (disp_data),
        .disp_blank     (disp_blank),
        .cur_page       (cur_page),
        .preview_active (preview_active)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: mode, shown page, the cycle of the last activity that
    // refreshes the timeout, and the cycle at which the blinking field last
    // became visible.
    typedef enum int {M_NORMAL, M_BROWSE, M_PREVIEW, M_EDIT} mode_e;
    mode_e         mMode      = M_NORMAL;
    mode_e         mOld       = M_NORMAL;
    int            mPage      = 0;
    int            mCycle     = 0;
    int            mLastAct   = 0;
    int            mVisStart  = 0;
    logic          mPrevReq   = 1'b0;
    logic          mPrevAdj   = 1'b0;
    logic [1:0]    mPrevField = 2'd0;
    logic          mRise      = 1'b0;
    logic [DW-1:0] mData      = '0;
    logic [NF-1:0] mBlank     = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mMode = M_NORMAL; mPage = 0; mCycle = 0; mLastAct = 0; mVisStart = 0;
            mPrevReq = 1'b0; mPrevAdj = 1'b0; mPrevField = 2'd0;
            mData = '0; mBlank = '0;
        end else begin
            mCycle++;
            mData = page_data[mPage*DW +: DW];
            mRise = preview_req && !mPrevReq;
            mOld  = mMode;
            if (edit_en) begin
                mMode = M_EDIT;
                mPage = (edit_page < NP) ? int'(edit_page) : 0;
            end else if (mMode == M_EDIT) begin
                mMode = M_NORMAL; mPage = 0;
            end else if (mRise || (mMode == M_PREVIEW && preview_req)) begin
                mMode = M_PREVIEW; mPage = 1; mLastAct = mCycle;
            end else if (mMode == M_PREVIEW) begin
                if (mCycle - mLastAct >= TOUT) begin mMode = M_NORMAL; mPage = 0; end
            end else if (page_next) begin
                mPage = (mPage + 1) % NP;
                mMode = (mPage == 0) ? M_NORMAL : M_BROWSE;
                mLastAct = mCycle;
            end else if (mMode == M_BROWSE && (mCycle - mLastAct >= TOUT)) begin
                mMode = M_NORMAL; mPage = 0;
            end
            if (mMode == M_EDIT && (mOld != M_EDIT || edit_field != mPrevField || edit_adj || mPrevAdj))
                mVisStart = mCycle;
            mBlank = '0;
            if (mMode == M_EDIT && !edit_adj && edit_field < NF && ((mCycle - mVisStart) / HALF) % 2 == 1)
                mBlank[edit_field] = 1'b1;
            mPrevReq   = preview_req;
            mPrevAdj   = edit_adj;
            mPrevField = edit_field;
        end
    end

    always @(negedge clk) begin
        checkOutput("model disp_data", 32'(disp_data), 32'(mData));
        checkOutput("model cur_page", 32'(cur_page), 32'(mPage));
        checkOutput("model disp_blank", 32'(disp_blank), 32'(mBlank));
        checkOutput("model preview_active", 32'(preview_active), 32'(mMode == M_PREVIEW));
    end

    // Drives one input vector for n clock edges; page_next is a single-cycle pulse.
    task automatic applyStimulus(input logic en, input logic [1:0] pg, input logic [1:0] fld,
                                 input logic adj, input logic req, input logic nxt, input int n);
        edit_en = en; edit_page = pg; edit_field = fld;
        edit_adj = adj; preview_req = req; page_next = nxt;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            page_next = 1'b0;
        end
    endtask

    task automatic idleInputs();
        edit_en = 1'b0; edit_page = 2'd0; edit_field = 2'd0;
        edit_adj = 1'b0; preview_req = 1'b0; page_next = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0] blinkPat [14];
        blinkPat = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b010,
                     3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010};
        page_data = 72'hAABBCC_789ABC_123456;

        repeat (2) @(negedge clk);
        checkOutput("reset disp_data", 32'(disp_data), 32'h0);
        checkOutput("reset cur_page", 32'(cur_page), 32'd0);
        checkOutput("reset blank", 32'(disp_blank), 32'd0);
        checkOutput("reset preview", 32'(preview_active), 32'd0);
        rst_n = 1'b1;

        applyStimulus(0, 0, 0, 0, 0, 0, 2);
        checkOutput("home data", 32'(disp_data), 32'h123456);
        checkOutput("home page", 32'(cur_page), 32'd0);
        checkOutput("home blank", 32'(disp_blank), 32'd0);
        checkOutput("model home data", 32'(mData), 32'h123456);

        // Browse one page, then let it time out
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("browse page", 32'(cur_page), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("browse data", 32'(disp_data), 32'h789ABC);
        applyStimulus(0, 0, 0, 0, 0, 0, 8);
        checkOutput("browse before timeout", 32'(cur_page), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("browse timeout", 32'(cur_page), 32'd0);
        checkOutput("model browse timeout", 32'(mPage), 32'd0);

        // Browse all the way round
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("browse x1", 32'(cur_page), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("browse x2", 32'(cur_page), 32'd2);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("browse x3", 32'(cur_page), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 12);
        checkOutput("normal stays home", 32'(cur_page), 32'd0);

        // Preview held 20 cycles then released
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 1);
            checkOutput("preview held page", 32'(cur_page), 32'd1);
            checkOutput("preview held active", 32'(preview_active), 32'd1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 9);
        checkOutput("preview release page", 32'(cur_page), 32'd1);
        checkOutput("preview release active", 32'(preview_active), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("preview timeout page", 32'(cur_page), 32'd0);
        checkOutput("preview timeout active", 32'(preview_active), 32'd0);

        // Preview rise and page_next together: preview wins
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        checkOutput("rise+next active", 32'(preview_active), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 1, 10);
        checkOutput("preview ignores next", 32'(cur_page), 32'd0);

        // Preview from BROWSE
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("browse page 2", 32'(cur_page), 32'd2);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        checkOutput("browse->preview page", 32'(cur_page), 32'd1);
        checkOutput("browse->preview active", 32'(preview_active), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 10);
        checkOutput("browse preview home", 32'(cur_page), 32'd0);

        // EDIT blink sequence, field change mid-blank
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, 2, 1, 0, 0, 0, 1);
            checkOutput("edit blink", 32'(disp_blank), 32'(blinkPat[i]));
        end
        checkOutput("edit page", 32'(cur_page), 32'd2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 2, 0, 0, 0, 0, 1);
            checkOutput("field change visible", 32'(disp_blank), 32'b000);
        end
        applyStimulus(1, 2, 0, 0, 0, 0, 1);
        checkOutput("field change blank", 32'(disp_blank), 32'b001);

        // Adjust held forces visibility; release restarts a full visible half
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 2, 0, 1, 0, 0, 1);
            checkOutput("adj held", 32'(disp_blank), 32'b000);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 2, 0, 0, 0, 0, 1);
            checkOutput("adj release visible", 32'(disp_blank), 32'b000);
        end
        applyStimulus(1, 2, 0, 0, 0, 0, 1);
        checkOutput("adj release blank", 32'(disp_blank), 32'b001);

        // Out-of-range edit page clamps home
        applyStimulus(1, 3, 0, 0, 0, 0, 1);
        checkOutput("edit clamp", 32'(cur_page), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("edit exit page", 32'(cur_page), 32'd0);
        checkOutput("edit exit blank", 32'(disp_blank), 32'd0);

        // edit_en and page_next together: EDIT wins
        applyStimulus(1, 1, 2, 0, 0, 1, 1);
        checkOutput("edit beats next", 32'(cur_page), 32'd1);
        applyStimulus(1, 1, 2, 0, 0, 0, 1);
        checkOutput("edit page data", 32'(disp_data), 32'h789ABC);
        applyStimulus(0, 0, 0, 0, 0, 0, 2);

        // Asynchronous reset mid-PREVIEW
        applyStimulus(0, 0, 0, 0, 1, 0, 3);
        checkOutput("pre-reset preview", 32'(preview_active), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async rst preview page", 32'(cur_page), 32'd0);
        checkOutput("async rst preview active", 32'(preview_active), 32'd0);
        checkOutput("async rst preview data", 32'(disp_data), 32'h0);
        @(negedge clk);
        idleInputs();
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 2);

        // Asynchronous reset mid-blank
        applyStimulus(1, 2, 2, 0, 0, 0, 6);
        checkOutput("pre-reset blank", 32'(disp_blank), 32'b100);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async rst blank", 32'(disp_blank), 32'd0);
        checkOutput("async rst edit page", 32'(cur_page), 32'd0);
        checkOutput("async rst edit data", 32'(disp_data), 32'h0);
        @(negedge clk);
        idleInputs();
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 2);
        checkOutput("post-reset data", 32'(disp_data), 32'h123456);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
